// File: rtl/axil_regfile_master_if.sv
// -----------------------------------------------------------------------------
// axil_regfile_master_if
//   AXI4-Lite bus bundle between the fabric-side register master and the
//   slv_reg/slv_read register file (through the interconnect).
//   Parameters: ADDR_WIDTH (byte address width), DATA_WIDTH (32 only).
//   Modports:
//     master : drives AW/W/AR payload+valid, bready, rready
//     slave  : drives awready, wready, B payload+valid, arready, R payload+valid
// -----------------------------------------------------------------------------
interface axil_regfile_master_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
   logic [2:0]              m_axi_awprot;
   logic                    m_axi_awvalid;
   logic                    m_axi_awready;

   logic [DATA_WIDTH-1:0]   m_axi_wdata;
   logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
   logic                    m_axi_wvalid;
   logic                    m_axi_wready;

   logic [1:0]              m_axi_bresp;
   logic                    m_axi_bvalid;
   logic                    m_axi_bready;

   logic [ADDR_WIDTH-1:0]   m_axi_araddr;
   logic [2:0]              m_axi_arprot;
   logic                    m_axi_arvalid;
   logic                    m_axi_arready;

   logic [DATA_WIDTH-1:0]   m_axi_rdata;
   logic [1:0]              m_axi_rresp;
   logic                    m_axi_rvalid;
   logic                    m_axi_rready;

   modport master (
      output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid,
      output m_axi_bready,
      output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      output m_axi_rready
   );

   modport slave (
      input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready,
      input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      input  m_axi_rready
   );
endinterface

// File: rtl/axil_regfile_master.sv
// -----------------------------------------------------------------------------
// axil_regfile_master
//   AXI4-Lite initiator turning single-word register commands from fabric
//   logic into AXI4-Lite transactions. One transaction outstanding at a time;
//   each command produces one response carrying read data and BRESP/RRESP.
//
//   Optional build macro: AXIL_REGFILE_MASTER_TIMEOUT_EN
//     defined   : watchdog of TIMEOUT_CYCLES busy cycles; on expiry the bus
//                 outputs drop and a SLVERR response with rsp_timeout=1 is
//                 returned.
//     undefined : no watchdog, rsp_timeout stays 0, waits forever.
//
//   Ports:
//     axi_aclk, axi_areset      clock, synchronous active-high reset
//     cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//     cmd_write/addr/wdata/wstrb command payload (addr[1:0] ignored)
//     rsp_valid/rsp_ready       response handshake, held until consumed
//     rsp_rdata/resp/timeout    response payload (rdata=0 for writes)
//     m_axi                     AXI4-Lite master bus (interface modport)
// -----------------------------------------------------------------------------
module axil_regfile_master #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    axi_aclk,
   input  logic                    axi_areset,

   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,

   axil_regfile_master_if.master   m_axi
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WRESP,
      READ,
      RDATA,
      RESP
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              resp_q, resp_d;
   logic                    timeout_q, timeout_d;

   logic                    accept;
   logic                    busy;
   logic                    expired;

   assign accept = (state_q == IDLE) && cmd_valid;
   assign busy   = (state_q == WRITE) || (state_q == WRESP) ||
                   (state_q == READ)  || (state_q == RDATA);

   // Low address bits are dropped on capture, so they are never observed.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^cmd_addr[1:0];

`ifdef AXIL_REGFILE_MASTER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts busy cycles since accept; expires on the TIMEOUT_CYCLES-th one.
   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = '0;
      end else if (busy) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign expired = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign expired            = 1'b0;
`endif

   // Bus outputs decode straight from registered state, so every valid/ready
   // is glitch-free and drops to 0 in reset/IDLE/RESP (late B/R beats ignored).
   assign cmd_ready            = (state_q == IDLE);
   assign rsp_valid            = (state_q == RESP);
   assign rsp_rdata            = rdata_q;
   assign rsp_resp             = resp_q;
   assign rsp_timeout          = timeout_q;

   assign m_axi.m_axi_awaddr   = addr_q;
   assign m_axi.m_axi_awprot   = 3'b000;
   assign m_axi.m_axi_awvalid  = (state_q == WRITE) && !aw_done_q;
   assign m_axi.m_axi_wdata    = wdata_q;
   assign m_axi.m_axi_wstrb    = wstrb_q;
   assign m_axi.m_axi_wvalid   = (state_q == WRITE) && !w_done_q;
   assign m_axi.m_axi_bready   = (state_q == WRESP);
   assign m_axi.m_axi_araddr   = addr_q;
   assign m_axi.m_axi_arprot   = 3'b000;
   assign m_axi.m_axi_arvalid  = (state_q == READ);
   assign m_axi.m_axi_rready   = (state_q == RDATA);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      timeout_d = timeout_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d    = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = cmd_write ? WRITE : READ;
            end
         end

         WRITE: begin
            // AW and W complete independently, in either order or together.
            if (m_axi.m_axi_awvalid && m_axi.m_axi_awready) begin
               aw_done_d = 1'b1;
            end
            if (m_axi.m_axi_wvalid && m_axi.m_axi_wready) begin
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               state_d = WRESP;
            end
         end

         WRESP: begin
            if (m_axi.m_axi_bvalid) begin
               resp_d    = m_axi.m_axi_bresp;
               rdata_d   = '0;
               timeout_d = 1'b0;
               state_d   = RESP;
            end
         end

         READ: begin
            if (m_axi.m_axi_arready) begin
               state_d = RDATA;
            end
         end

         RDATA: begin
            if (m_axi.m_axi_rvalid) begin
               rdata_d   = m_axi.m_axi_rdata;
               resp_d    = m_axi.m_axi_rresp;
               timeout_d = 1'b0;
               state_d   = RESP;
            end
         end

         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // A genuine B/R beat on the last allowed cycle still wins over the
      // watchdog; otherwise the transaction is abandoned with SLVERR.
      if (expired && (state_d != RESP)) begin
         state_d   = RESP;
         resp_d    = 2'b10;
         rdata_d   = '0;
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_axil_regfile_master.sv
// -----------------------------------------------------------------------------
// tb_axil_regfile_master
//   Self-checking bench for axil_regfile_master. A behavioural AXI4-Lite
//   register-file slave with programmable channel delays answers the DUT;
//   expected responses come from a word-array reference model of the register
//   map (0x00..0x3F OKAY, 0x40..0x7F SLVERR, 0x80.. DECERR).
//   All DUT outputs are sampled and all inputs driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_axil_regfile_master;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;

   axil_regfile_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axil_regfile_master #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .axi_aclk   (clk),
      .axi_areset (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .cmd_wstrb  (cmd_wstrb),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_resp   (rsp_resp),
      .rsp_timeout(rsp_timeout),
      .m_axi      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   logic [31:0] ref_mem [16];

   function automatic logic [1:0] region_resp(input logic [31:0] a);
      if (a < 32'h40)      return 2'b00;
      else if (a < 32'h80) return 2'b10;
      else                 return 2'b11;
   endfunction

   task automatic model_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] exp_rdata,
                            output logic [1:0] exp_resp);
      int unsigned word;
      word      = addr[5:2];
      exp_resp  = region_resp(addr);
      exp_rdata = '0;
      if (wr) begin
         if (exp_resp == 2'b00) begin
            for (int unsigned b = 0; b < 4; b++) begin
               if (strb[b]) ref_mem[word][8*b +: 8] = data[8*b +: 8];
            end
         end
      end else if (exp_resp == 2'b00) begin
         exp_rdata = ref_mem[word];
      end
   endtask

   // ---------------------------------------------------------------- slave
   logic [31:0] slv_mem [16];
   int unsigned aw_wait, w_wait, ar_wait, b_wait, r_wait;
   bit          rand_delays, ar_block;
   bit          aw_got, w_got, ar_got, b_sched, r_sched;
   bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0]  cap_wstrb;
   bit          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
   logic [31:0] p_awaddr, p_wdata, p_araddr;
   logic [3:0]  p_wstrb;
   int unsigned proto_err, b_hs_cnt, r_hs_cnt;

   function automatic void new_delays();
      aw_wait = rand_delays ? $urandom_range(0, 3) : 0;
      w_wait  = rand_delays ? $urandom_range(0, 3) : 0;
      ar_wait = rand_delays ? $urandom_range(0, 3) : 0;
      b_wait  = rand_delays ? $urandom_range(0, 3) : 0;
      r_wait  = rand_delays ? $urandom_range(0, 3) : 0;
   endfunction

   initial begin
      for (int unsigned i = 0; i < 16; i++) slv_mem[i] = '0;
      slv_mem[0] = 32'hDEADBEEF;
      slv_mem[1] = 32'h76543210;
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      bus.m_axi_bvalid  = 1'b0;
      bus.m_axi_bresp   = 2'b00;
      bus.m_axi_arready = 1'b0;
      bus.m_axi_rvalid  = 1'b0;
      bus.m_axi_rresp   = 2'b00;
      bus.m_axi_rdata   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.m_axi_awready = 1'b0;
            bus.m_axi_wready  = 1'b0;
            bus.m_axi_bvalid  = 1'b0;
            bus.m_axi_arready = 1'b0;
            bus.m_axi_rvalid  = 1'b0;
            {aw_got, w_got, ar_got, b_sched, r_sched} = '0;
            {hs_aw, hs_w, hs_b, hs_ar, hs_r} = '0;
            {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} = '0;
            new_delays();
         end else begin
            // retire handshakes that completed on the last rising edge
            if (hs_aw) aw_got = 1'b1;
            if (hs_w)  w_got  = 1'b1;
            if (hs_ar) ar_got = 1'b1;
            if (hs_b) begin
               bus.m_axi_bvalid = 1'b0;
               {b_sched, aw_got, w_got} = '0;
               b_hs_cnt++;
               new_delays();
            end
            if (hs_r) begin
               bus.m_axi_rvalid = 1'b0;
               {r_sched, ar_got} = '0;
               r_hs_cnt++;
               new_delays();
            end

            // protocol observations
            if ((bus.m_axi_awvalid || bus.m_axi_wvalid) && bus.m_axi_arvalid) proto_err++;
            if (bus.m_axi_bready && bus.m_axi_rready) proto_err++;
            if (bus.m_axi_awvalid && (bus.m_axi_awaddr[1:0] != 2'b00 || bus.m_axi_awprot != 3'b000)) proto_err++;
            if (bus.m_axi_arvalid && (bus.m_axi_araddr[1:0] != 2'b00 || bus.m_axi_arprot != 3'b000)) proto_err++;
            if (bus.m_axi_awvalid && aw_got) proto_err++;
            if (bus.m_axi_wvalid && w_got) proto_err++;
            if (bus.m_axi_arvalid && ar_got) proto_err++;
            if (p_awv && !p_awr && (!bus.m_axi_awvalid || bus.m_axi_awaddr != p_awaddr)) proto_err++;
            if (p_wv && !p_wr && (!bus.m_axi_wvalid || bus.m_axi_wdata != p_wdata ||
                                  bus.m_axi_wstrb != p_wstrb)) proto_err++;
            if (p_arv && !p_arr && (!bus.m_axi_arvalid || bus.m_axi_araddr != p_araddr)) proto_err++;

            // AW / W
            bus.m_axi_awready = 1'b0;
            if (bus.m_axi_awvalid && !aw_got) begin
               if (aw_wait > 0) aw_wait--;
               else bus.m_axi_awready = 1'b1;
            end
            hs_aw = bus.m_axi_awvalid && bus.m_axi_awready;
            if (hs_aw) cap_awaddr = bus.m_axi_awaddr;

            bus.m_axi_wready = 1'b0;
            if (bus.m_axi_wvalid && !w_got) begin
               if (w_wait > 0) w_wait--;
               else bus.m_axi_wready = 1'b1;
            end
            hs_w = bus.m_axi_wvalid && bus.m_axi_wready;
            if (hs_w) begin
               cap_wdata = bus.m_axi_wdata;
               cap_wstrb = bus.m_axi_wstrb;
            end

            // B
            if (aw_got && w_got && !b_sched) begin
               b_sched         = 1'b1;
               bus.m_axi_bresp = region_resp(cap_awaddr);
               if (bus.m_axi_bresp == 2'b00) begin
                  for (int unsigned b = 0; b < 4; b++) begin
                     if (cap_wstrb[b]) slv_mem[cap_awaddr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
                  end
               end
            end
            if (b_sched && !bus.m_axi_bvalid) begin
               if (b_wait > 0) b_wait--;
               else bus.m_axi_bvalid = 1'b1;
            end
            hs_b = bus.m_axi_bvalid && bus.m_axi_bready;

            // AR / R
            bus.m_axi_arready = 1'b0;
            if (bus.m_axi_arvalid && !ar_got && !ar_block) begin
               if (ar_wait > 0) ar_wait--;
               else bus.m_axi_arready = 1'b1;
            end
            hs_ar = bus.m_axi_arvalid && bus.m_axi_arready;
            if (hs_ar) cap_araddr = bus.m_axi_araddr;

            if (ar_got && !r_sched) begin
               r_sched         = 1'b1;
               bus.m_axi_rresp = region_resp(cap_araddr);
               bus.m_axi_rdata = (bus.m_axi_rresp == 2'b00) ? slv_mem[cap_araddr[5:2]] : 32'h0;
            end
            if (r_sched && !bus.m_axi_rvalid) begin
               if (r_wait > 0) r_wait--;
               else bus.m_axi_rvalid = 1'b1;
            end
            hs_r = bus.m_axi_rvalid && bus.m_axi_rready;

            p_awv = bus.m_axi_awvalid; p_awr = bus.m_axi_awready; p_awaddr = bus.m_axi_awaddr;
            p_wv  = bus.m_axi_wvalid;  p_wr  = bus.m_axi_wready;  p_wdata  = bus.m_axi_wdata;
            p_wstrb = bus.m_axi_wstrb;
            p_arv = bus.m_axi_arvalid; p_arr = bus.m_axi_arready; p_araddr = bus.m_axi_araddr;
         end
      end
   end

   // ---------------------------------------------------------------- driver
   task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int unsigned hold,
                         output logic [31:0] got_rdata, output logic [1:0] got_resp,
                         output int unsigned lat);
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      logic        got_to;
      int unsigned busy_err, stab_err, n;
      model_cmd(wr, addr, data, strb, exp_rdata, exp_resp);
      b_hs_cnt  = 0;
      r_hs_cnt  = 0;
      proto_err = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      cmd_wstrb = strb;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat       = 1;
      busy_err  = 0;
      while (!rsp_valid && lat < 200) begin
         if (cmd_ready) busy_err++;
         @(negedge clk);
         lat++;
      end
      check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
      got_rdata = rsp_rdata;
      got_resp  = rsp_resp;
      got_to    = rsp_timeout;
      stab_err  = 0;
      for (int unsigned i = 0; i < hold; i++) begin
         if (cmd_ready || !rsp_valid || rsp_rdata != got_rdata || rsp_resp != got_resp ||
             rsp_timeout != got_to) stab_err++;
         @(negedge clk);
      end
      if (cmd_ready || !rsp_valid || rsp_rdata != got_rdata || rsp_resp != got_resp ||
          rsp_timeout != got_to) stab_err++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("busy_cmd_ready", busy_err, 0);
      check("rsp_stable", stab_err, 0);
      check("rsp_rdata", got_rdata, exp_rdata);
      check("rsp_resp", 32'(got_resp), 32'(exp_resp));
      check("rsp_timeout", 32'(got_to), 32'd0);
      check("axi_protocol", proto_err, 0);
      check("b_handshakes", b_hs_cnt, wr ? 32'd1 : 32'd0);
      check("r_handshakes", r_hs_cnt, wr ? 32'd0 : 32'd1);
      check("post_cmd_ready", 32'(cmd_ready), 32'd1);
      check("post_rsp_valid", 32'(rsp_valid), 32'd0);
   endtask

   // ---------------------------------------------------------------- main
   logic [31:0] rd;
   logic [1:0]  rs;
   int unsigned lt, n;

   initial begin
      for (int unsigned i = 0; i < 16; i++) ref_mem[i] = '0;
      ref_mem[0] = 32'hDEADBEEF;
      ref_mem[1] = 32'h76543210;
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b0;
      rand_delays = 1'b0;
      ar_block    = 1'b0;
      proto_err = 0; b_hs_cnt = 0; r_hs_cnt = 0;
      new_delays();

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_handshakes", 32'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                                    bus.m_axi_arvalid, bus.m_axi_rready, rsp_valid}), 32'd0);
      check("rst_rsp", 32'({rsp_resp, rsp_timeout}), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_awaddr", bus.m_axi_awaddr, 32'd0);
      check("rst_wdata", bus.m_axi_wdata, 32'd0);
      rst = 1'b0;

      // zero-wait slave: register map contents and minimum latency
      do_cmd(1'b0, 32'h00, '0, 4'h0, 0, rd, rs, lt);
      check("tp_rd00_data", rd, 32'hDEADBEEF);
      check("tp_rd00_resp", 32'(rs), 32'd0);
      check("tp_rd_latency", lt, 32'd3);
      do_cmd(1'b0, 32'h04, '0, 4'h0, 0, rd, rs, lt);
      check("tp_rd04_data", rd, 32'h76543210);
      do_cmd(1'b1, 32'h14, 32'hA5A51234, 4'hF, 0, rd, rs, lt);
      check("tp_wr14_resp", 32'(rs), 32'd0);
      check("tp_wr_latency", lt, 32'd3);
      check("tp_wr14_rdata", rd, 32'd0);
      do_cmd(1'b0, 32'h17, '0, 4'h0, 1, rd, rs, lt);
      check("tp_rd14_data", rd, 32'hA5A51234);
      do_cmd(1'b1, 32'h18, 32'hFFFFFFFF, 4'hF, 0, rd, rs, lt);
      do_cmd(1'b1, 32'h18, 32'h00000000, 4'b0011, 0, rd, rs, lt);
      do_cmd(1'b0, 32'h18, '0, 4'h0, 0, rd, rs, lt);
      check("tp_rd18_strb", rd, 32'hFFFF0000);

      // error responses pass through unchanged
      do_cmd(1'b1, 32'h44, 32'h12345678, 4'hF, 0, rd, rs, lt);
      check("tp_wr44_slverr", 32'(rs), 32'd2);
      do_cmd(1'b0, 32'h84, '0, 4'h0, 0, rd, rs, lt);
      check("tp_rd84_decerr", 32'(rs), 32'd3);

      // stalled AW/W and back-pressured response
      @(negedge clk);
      aw_wait = 5;
      w_wait  = 2;
      do_cmd(1'b1, 32'h20, 32'hCAFE0001, 4'hF, 3, rd, rs, lt);
      check("tp_stall_latency", lt, 32'd8);

      // reset while waiting for R
      @(negedge clk);
      r_wait    = 10;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h04;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!bus.m_axi_rready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_reach_rdata", 32'(bus.m_axi_rready), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_handshakes", 32'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                                       bus.m_axi_arvalid, bus.m_axi_rready, rsp_valid}), 32'd0);
      check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("midrst_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      new_delays();

`ifdef AXIL_REGFILE_MASTER_TIMEOUT_EN
      // watchdog: AR never accepted
      ar_block = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h00;
      @(negedge clk);
      cmd_valid = 1'b0;
      lt = 1;
      while (!rsp_valid && lt < 100) begin
         @(negedge clk);
         lt++;
      end
      check("to_latency", lt, 32'd17);
      check("to_arvalid", 32'(bus.m_axi_arvalid), 32'd0);
      check("to_rsp_resp", 32'(rsp_resp), 32'd2);
      check("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
      check("to_rsp_rdata", rsp_rdata, 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      ar_block  = 1'b0;
      repeat (2) @(negedge clk);
`endif

      // randomized traffic against the reference model
      rand_delays = 1'b1;
      new_delays();
      for (int unsigned t = 0; t < 40; t++) begin
         do_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'hBF)), $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 3), rd, rs, lt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
